// File: rtl/dmem_responder_if.sv
// ============================================================================
// dmem_responder_if : core data-port bus between the memory stage and dmem.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;

    modport master (
        output MemWriteM,
        output ALUResultM,
        output WriteDataM,
        input  ReadDataM
    );

    modport slave (
        input  MemWriteM,
        input  ALUResultM,
        input  WriteDataM,
        output ReadDataM
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : word RAM + MMIO (CYCLE, TOHOST, LOGSTAT) + optional store log.
// Optional feature macro: DMEM_WRITE_LOG_EN.    Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int          MEM_WORDS = 64,
    parameter int          LOG_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_FF00
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output logic            done,
    output logic [31:0]     done_code,
    output logic            log_valid,
    input  logic            log_ready,
    output logic [31:0]     log_addr,
    output logic [31:0]     log_data,
    output logic            log_overflow
);
    localparam int          c_AW        = $clog2(MEM_WORDS);
    localparam logic [29:0] c_CYCLE_W   = MMIO_BASE[31:2];
    localparam logic [29:0] c_TOHOST_W  = MMIO_BASE[31:2] + 30'd1;
    localparam logic [29:0] c_LOGSTAT_W = MMIO_BASE[31:2] + 30'd2;

    logic [31:0]     w_addr;
    logic [29:0]     w_word;
    logic [c_AW-1:0] w_idx;
    logic            w_ram_hit;
    logic            w_hit_cycle;
    logic            w_hit_tohost;
    logic            w_hit_logstat;
    logic            w_ram_we;
    logic [31:0]     w_logstat;
    logic            w_unused_addr;

    logic [31:0]     r_cycle;
    logic [31:0]     r_mem [MEM_WORDS];

    assign w_addr        = bus.ALUResultM;
    assign w_word        = w_addr[31:2];
    assign w_idx         = w_addr[c_AW+1:2];
    assign w_ram_hit     = (w_addr[31:c_AW+2] == '0);
    assign w_hit_cycle   = (w_word == c_CYCLE_W);
    assign w_hit_tohost  = (w_word == c_TOHOST_W);
    assign w_hit_logstat = (w_word == c_LOGSTAT_W);
    assign w_ram_we      = bus.MemWriteM && w_ram_hit;
    assign w_unused_addr = ^w_addr[1:0];

    // RAM has no reset so that contents survive a core restart
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= bus.WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle   <= '0;
            done      <= 1'b0;
            done_code <= '0;
        end else begin
            r_cycle <= (bus.MemWriteM && w_hit_cycle) ? '0 : r_cycle + 32'd1;
            if (bus.MemWriteM && w_hit_tohost && !done && (bus.WriteDataM != '0)) begin
                done      <= 1'b1;
                done_code <= bus.WriteDataM;
            end
        end
    end

    // Loads see pre-edge state: a same-cycle store is not bypassed
    always_comb begin
        bus.ReadDataM = '0;
        if (w_ram_hit) begin
            bus.ReadDataM = r_mem[w_idx];
        end else if (w_hit_cycle) begin
            bus.ReadDataM = r_cycle;
        end else if (w_hit_tohost) begin
            bus.ReadDataM = done_code;
        end else if (w_hit_logstat) begin
            bus.ReadDataM = w_logstat;
        end
    end

`ifdef DMEM_WRITE_LOG_EN
    localparam int c_PW = $clog2(LOG_DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [31:0]     r_fifo_addr [LOG_DEPTH];
    logic [31:0]     r_fifo_data [LOG_DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic            w_full;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;

    assign w_full  = (r_count == c_CW'(LOG_DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && log_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign w_push  = w_ram_we && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= {w_word, 2'b00};
            r_fifo_data[r_wptr] <= bus.WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ram_we && !w_push) r_ovf <= 1'b1;
        end
    end

    assign log_valid    = w_valid;
    assign log_addr     = w_valid ? r_fifo_addr[r_rptr] : '0;
    assign log_data     = w_valid ? r_fifo_data[r_rptr] : '0;
    assign log_overflow = r_ovf;
    assign w_logstat    = {23'b0, r_ovf, 8'(r_count)};
`else
    logic w_unused_log;

    assign w_unused_log = log_ready;
    assign log_valid    = 1'b0;
    assign log_addr     = '0;
    assign log_data     = '0;
    assign log_overflow = 1'b0;
    assign w_logstat    = '0;
`endif

endmodule

`default_nettype wire
